dma_priority_arbiter: RTL and testbench

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

---
 rtl/dma_priority_arbiter_pkg.sv | 23 ++
 rtl/dma_priority_arbiter_if.sv | 35 +++
 rtl/dma_prio_encoder.sv | 32 +++
 rtl/dma_priority_arbiter.sv | 98 +++++++++
 tb/tb_dma_priority_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and helpers for the DMA priority arbiter.
package dma_priority_arbiter_pkg;

    localparam int NUM_CH_MAX = 8;
    localparam int CH_IDX_W   = $clog2(NUM_CH_MAX);

    // Channel index wide enough for the largest supported configuration
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // One-hot encoded arbiter states
    typedef enum logic [3:0] {
        ARB_IDLE    = 4'b0001,
        ARB_HRQ     = 4'b0010,
        ARB_GRANT   = 4'b0100,
        ARB_RELEASE = 4'b1000
    } arb_state_e;

    // (base + off) modulo n, used for rotating priority and pointer advance
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the arbiter and its environment.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4
);
    import dma_priority_arbiter_pkg::*;

    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] dreq;
    logic [NUM_CH-1:0] dreq_pol;
    logic [NUM_CH-1:0] dack_pol;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] sw_req;
    logic              rotating;
    logic              ctrl_disable;
    logic              hlda;
    logic              eop;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic [CW-1:0]     active_ch;
    logic              grant_valid;

    modport slave (
        input  dreq, dreq_pol, dack_pol, mask, sw_req,
        input  rotating, ctrl_disable, hlda, eop,
        output hrq, dack, active_ch, grant_valid
    );

    modport master (
        output dreq, dreq_pol, dack_pol, mask, sw_req,
        output rotating, ctrl_disable, hlda, eop,
        input  hrq, dack, active_ch, grant_valid
    );

endinterface

// File: rtl/dma_prio_encoder.sv
// Combinational priority encoder: fixed (ch0 highest) or rotating from ptr.
module dma_prio_encoder #(
    parameter  int NUM_CH = 4,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eff_req,
    input  logic [CW-1:0]     ptr,
    input  logic              rotating,
    output logic [CW-1:0]     winner,
    output logic              found
);
    import dma_priority_arbiter_pkg::*;

    logic [CW-1:0] base;
    ch_idx_t       cand;

    // Scan channels starting at base; the first requesting one wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        base   = rotating ? ptr : '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = ch_idx_t'(wrap_idx(int'(base), k, NUM_CH));
            if (!found && eff_req[cand[CW-1:0]]) begin
                found  = 1'b1;
                winner = cand[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: hold request / acknowledge handshake with priority grant.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_priority_arbiter_if.slave bus
);
    import dma_priority_arbiter_pkg::*;

    localparam int CW = $clog2(NUM_CH);

    arb_state_e        state_reg;
    arb_state_e        state_next;
    logic [NUM_CH-1:0] eff_req;
    logic [NUM_CH-1:0] grant_onehot_reg;
    logic [CW-1:0]     active_ch_reg;
    logic [CW-1:0]     ptr_reg;
    logic [CW-1:0]     ptr_next;
    logic [CW-1:0]     winner;
    logic              found;
    logic              grant_valid_reg;

    // Per-channel request conditioning and acknowledge polarity
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign eff_req[gi]  = ((bus.dreq[gi] ^ bus.dreq_pol[gi]) & ~bus.mask[gi])
                              | bus.sw_req[gi];
        assign bus.dack[gi] = grant_onehot_reg[gi] ^ bus.dack_pol[gi];
    end

    dma_prio_encoder #(.NUM_CH(NUM_CH)) u_enc (
        .eff_req  (eff_req),
        .ptr      (ptr_reg),
        .rotating (bus.rotating),
        .winner   (winner),
        .found    (found)
    );

    // Rotation pointer moves to the channel after the one just served
    assign ptr_next = CW'(wrap_idx(int'(active_ch_reg), 1, NUM_CH));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ARB_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:    if ((|eff_req) && !bus.ctrl_disable) state_next = ARB_HRQ;
            ARB_HRQ:     if (bus.hlda) state_next = found ? ARB_GRANT : ARB_RELEASE;
            ARB_GRANT:   if (bus.eop || !bus.hlda) state_next = ARB_RELEASE;
            ARB_RELEASE: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    // Grant capture on hlda, grant drop and pointer update on exit from service
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_onehot_reg <= '0;
            active_ch_reg    <= '0;
            grant_valid_reg  <= 1'b0;
            ptr_reg          <= '0;
        end else begin
            case (state_reg)
                ARB_HRQ: begin
                    if (bus.hlda && found) begin
                        active_ch_reg    <= winner;
                        grant_onehot_reg <= NUM_CH'(1) << winner;
                        grant_valid_reg  <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (bus.eop || !bus.hlda) begin
                        grant_onehot_reg <= '0;
                        grant_valid_reg  <= 1'b0;
                        if (bus.rotating) ptr_reg <= ptr_next;
                    end
                end
                default: begin
                    grant_onehot_reg <= '0;
                    grant_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.hrq         = (state_reg == ARB_HRQ) || (state_reg == ARB_GRANT);
        bus.active_ch   = active_ch_reg;
        bus.grant_valid = grant_valid_reg;
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter at NUM_CH=4 and NUM_CH=8.
module tb_dma_priority_arbiter;

    logic clk = 1'b0;
    logic rst4;
    logic rst8;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dma_priority_arbiter_if #(.NUM_CH(4)) bus4 ();
    dma_priority_arbiter_if #(.NUM_CH(8)) bus8 ();

    dma_priority_arbiter #(.NUM_CH(4)) u4 (.clk(clk), .reset(rst4), .bus(bus4.slave));
    dma_priority_arbiter #(.NUM_CH(8)) u8 (.clk(clk), .reset(rst8), .bus(bus8.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         ch;
        logic [3:0] dack;
        int         cyc;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic push_exp(input int ch, input logic [3:0] dk, input int lat);
        exp_t e;
        e.ch = ch; e.dack = dk; e.cyc = cyc; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Reference priority: first requester scanning up from the start channel
    function automatic int model_win(input logic [3:0] eff, input int p, input logic rot);
        int base = rot ? p : 0;
        for (int k = 0; k < 4; k++)
            if (eff[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    // Monitor: each new grant on the 4-channel DUT is matched against the queue
    logic gv_prev = 1'b0;
    always @(negedge clk) begin
        if (bus4.grant_valid === 1'b1 && gv_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected grant", 32'd1, 32'd0);
            end else begin
                check_val("grant active_ch", 32'(bus4.active_ch), sb_q[0].ch);
                check_val("grant dack", 32'(bus4.dack), 32'(sb_q[0].dack));
                check_val("grant latency", cyc - sb_q[0].cyc, sb_q[0].lat);
                $display("[TB] grant ch=%0d dack=%b at cycle %0d", bus4.active_ch, bus4.dack, cyc);
                void'(sb_q.pop_front());
            end
        end
        gv_prev <= bus4.grant_valid;
    end

    task automatic clear4();
        bus4.dreq = '0; bus4.dreq_pol = '0; bus4.dack_pol = '0; bus4.mask = '0;
        bus4.sw_req = '0; bus4.rotating = 1'b0; bus4.ctrl_disable = 1'b0;
        bus4.hlda = 1'b1; bus4.eop = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus4.grant_valid !== 1'b1 && n < 20);
        check_val({tag, " grant seen"}, 32'(bus4.grant_valid), 32'd1);
        check_val({tag, " hrq in grant"}, 32'(bus4.hrq), 32'd1);
    endtask

    // End service with eop (or abort via hlda low) and check release then idle
    task automatic finish_grant(input string tag, input logic [3:0] ap, input logic rot,
                                input int ch, input logic abort_it);
        bus4.sw_req = '0;
        bus4.dreq   = bus4.dreq_pol;
        if (abort_it) bus4.hlda = 1'b0;
        else          bus4.eop  = 1'b1;
        @(negedge clk);
        bus4.eop = 1'b0; bus4.hlda = 1'b1; bus4.mask = '0; bus4.ctrl_disable = 1'b0;
        check_val({tag, " release hrq"}, 32'(bus4.hrq), 32'd0);
        check_val({tag, " release gv"}, 32'(bus4.grant_valid), 32'd0);
        check_val({tag, " release dack"}, 32'(bus4.dack), 32'(ap));
        @(negedge clk);
        check_val({tag, " idle hrq"}, 32'(bus4.hrq), 32'd0);
        check_val({tag, " idle gv"}, 32'(bus4.grant_valid), 32'd0);
        if (rot) m_ptr = (ch + 1) % 4;
    endtask

    task automatic serve(input string tag, input logic [3:0] d, input logic [3:0] dp,
                         input logic [3:0] ap, input logic [3:0] m, input logic [3:0] sw,
                         input logic rot, input int exp_ch, input logic abort_it);
        logic [3:0] exp_dk;
        @(negedge clk);
        bus4.dreq = d; bus4.dreq_pol = dp; bus4.dack_pol = ap; bus4.mask = m;
        bus4.sw_req = sw; bus4.rotating = rot; bus4.hlda = 1'b1;
        bus4.ctrl_disable = 1'b0;
        exp_dk = (4'b0001 << exp_ch) ^ ap;
        push_exp(exp_ch, exp_dk, 2);
        wait_grant(tag);
        // Mask, disable and request withdrawal must not disturb a grant in progress
        bus4.mask = 4'hF; bus4.ctrl_disable = 1'b1; bus4.dreq = dp; bus4.sw_req = '0;
        @(negedge clk);
        check_val({tag, " hold gv"}, 32'(bus4.grant_valid), 32'd1);
        check_val({tag, " hold ch"}, 32'(bus4.active_ch), exp_ch);
        check_val({tag, " hold dack"}, 32'(bus4.dack), 32'(exp_dk));
        finish_grant(tag, ap, rot, exp_ch, abort_it);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd, rm, rs, eff;
        logic       rr, ra;
        int         ec;
        int         n;

        clear4();
        bus4.dack_pol = 4'b0101;
        bus8.dreq = '0; bus8.dreq_pol = '0; bus8.dack_pol = 8'hA5; bus8.mask = '0;
        bus8.sw_req = '0; bus8.rotating = 1'b0; bus8.ctrl_disable = 1'b0;
        bus8.hlda = 1'b1; bus8.eop = 1'b0;
        rst4 = 1'b1; rst8 = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst hrq", 32'(bus4.hrq), 32'd0);
        check_val("rst gv", 32'(bus4.grant_valid), 32'd0);
        check_val("rst active_ch", 32'(bus4.active_ch), 32'd0);
        check_val("rst dack", 32'(bus4.dack), 32'h5);
        check_val("rst8 dack", 32'(bus8.dack), 32'hA5);
        rst4 = 1'b0; rst8 = 1'b0;

        // Directed grants
        serve("fixed 1010",   4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 1'b0);
        serve("rot ch1",      4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1, 1'b0);
        serve("rot ptr2",     4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 1'b0);
        serve("polarity",     4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        serve("mask vs sw",   4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 1'b0, 2, 1'b0);
        serve("abort rot",    4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3, 1'b1);
        serve("after abort",  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 1'b0);

        // ctrl_disable blocks arbitration from idle
        @(negedge clk);
        clear4();
        bus4.ctrl_disable = 1'b1; bus4.dreq = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            check_val("disable hrq", 32'(bus4.hrq), 32'd0);
        end
        bus4.ctrl_disable = 1'b0;
        push_exp(0, 4'b0001, 2);
        wait_grant("disable");
        finish_grant("disable", 4'b0000, 1'b0, 0, 1'b0);

        // hrq waits for hlda, eop in HRQ is ignored
        @(negedge clk);
        clear4();
        bus4.hlda = 1'b0; bus4.dreq = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        check_val("hrq wait", 32'(bus4.hrq), 32'd1);
        bus4.eop = 1'b1;
        @(negedge clk);
        bus4.eop = 1'b0;
        check_val("eop in hrq hrq", 32'(bus4.hrq), 32'd1);
        check_val("eop in hrq gv", 32'(bus4.grant_valid), 32'd0);
        @(negedge clk);
        check_val("eop in hrq hrq2", 32'(bus4.hrq), 32'd1);
        bus4.hlda = 1'b1;
        push_exp(2, 4'b0100, 1);
        wait_grant("hlda late");
        finish_grant("hlda late", 4'b0000, 1'b0, 2, 1'b0);

        // Back-to-back with a held request: hrq low for exactly two cycles
        @(negedge clk);
        clear4();
        bus4.dreq = 4'b0010;
        push_exp(1, 4'b0010, 2);
        wait_grant("b2b first");
        bus4.eop = 1'b1;
        push_exp(1, 4'b0010, 4);
        @(negedge clk);
        bus4.eop = 1'b0;
        check_val("b2b release hrq", 32'(bus4.hrq), 32'd0);
        @(negedge clk);
        check_val("b2b idle hrq", 32'(bus4.hrq), 32'd0);
        @(negedge clk);
        check_val("b2b rehrq", 32'(bus4.hrq), 32'd1);
        wait_grant("b2b second");
        finish_grant("b2b second", 4'b0000, 1'b0, 1, 1'b0);

        // Random traffic checked against the reference priority model
        for (int i = 0; i < 8; i++) begin
            rd = 4'($urandom_range(0, 15));
            rm = 4'($urandom_range(0, 15));
            rs = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rr = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            eff = (rd & ~rm) | rs;
            if (eff == 4'b0000) begin
                rs  = 4'b1000;
                eff = 4'b1000;
            end
            ec = model_win(eff, m_ptr, rr);
            serve("random", rd, 4'b0000, 4'b0000, rm, rs, rr, ec, ra);
        end

        // 8-channel: reset in the middle of a grant
        @(negedge clk);
        bus8.dreq = 8'h40;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus8.grant_valid !== 1'b1 && n < 20);
        check_val("ch8 grant gv", 32'(bus8.grant_valid), 32'd1);
        check_val("ch8 grant ch", 32'(bus8.active_ch), 32'd6);
        check_val("ch8 grant dack", 32'(bus8.dack), 32'hE5);
        $display("[TB] grant8 ch=%0d dack=%b at cycle %0d", bus8.active_ch, bus8.dack, cyc);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0; bus8.dreq = '0; bus8.hlda = 1'b0;
        check_val("ch8 rst hrq", 32'(bus8.hrq), 32'd0);
        check_val("ch8 rst gv", 32'(bus8.grant_valid), 32'd0);
        check_val("ch8 rst dack", 32'(bus8.dack), 32'hA5);
        check_val("ch8 rst active_ch", 32'(bus8.active_ch), 32'd0);
        @(negedge clk);
        check_val("ch8 post rst hrq", 32'(bus8.hrq), 32'd0);

        // 8-channel: request withdrawn before hlda leads to release without dack
        bus8.dreq = 8'h02;
        @(negedge clk);
        check_val("ch8 wd hrq", 32'(bus8.hrq), 32'd1);
        bus8.dreq = '0;
        @(negedge clk);
        check_val("ch8 wd hold hrq", 32'(bus8.hrq), 32'd1);
        bus8.hlda = 1'b1;
        @(negedge clk);
        check_val("ch8 wd release hrq", 32'(bus8.hrq), 32'd0);
        check_val("ch8 wd release gv", 32'(bus8.grant_valid), 32'd0);
        check_val("ch8 wd release dack", 32'(bus8.dack), 32'hA5);
        @(negedge clk);
        check_val("ch8 wd idle hrq", 32'(bus8.hrq), 32'd0);
        check_val("ch8 wd idle gv", 32'(bus8.grant_valid), 32'd0);
        $display("[TB] withdraw8 done at cycle %0d", cyc);

        check_val("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
